uart_rx: RTL and testbench

Serial receiver for the UART path: recovers 8N1 bytes from the asynchronous `rx` line with 16x oversampling, checks framing, and buffers bytes for the CPU-side reader. Complements the transmit side of the `uart` block; the host bench drives it with 19200 baud frames from a 16 MHz system clock.

---
 rtl/uart_rx.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, framing check and a CPU-side byte buffer.
// Define UART_RX_FIFO_EN for a 2**ADDR_W-deep FIFO; otherwise a single holding register is used.
module uart_rx #(
    parameter int unsigned CLKS_PER_TICK = 52,
    parameter int unsigned ADDR_W        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [3:0]    s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          push, stop_err;
    logic          full, empty, rd_en, wr_en;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TW'(CLKS_PER_TICK - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        push     = 1'b0;
        stop_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                // edge detect, so a held-low break line never starts a frame
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        b_d = {rx_sync_q, b_q[7:1]};
                        s_d = '0;
                        if (n_q == 3'd7) state_d = STOP;
                        else             n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        push     = rx_sync_q;
                        stop_err = !rx_sync_q;
                        state_d  = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en       = rd && !empty;
        // a same-cycle pop frees the slot, so a full buffer still accepts the byte
        wr_en       = push && (!full || rd_en);
        done_d      = wr_en;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (stop_err)                     frame_err_d = 1'b1;
        if (push && full && !rd_en)       overrun_d   = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // extra pointer MSB separates full from empty when the index bits match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = b_q;
            wr_ptr_d                    = wr_ptr_q + 1'b1;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign rx_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign empty = !valid_q;
    assign full  = valid_q;

    always_comb begin
        hold_d  = wr_en ? b_q : hold_q;
        valid_d = wr_en || (valid_q && !rd_en);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data = hold_q;
`endif

    assign rx_empty     = empty;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven with an exact 16-tick bit period,
// start edges aligned to the tick phase so stop-sample timing is known in advance.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPT = 2;
    localparam int BIT = 16 * CPT;
    // start edge driven at even cycle k0: stop sampled at k0+305, done visible at k0+306
    localparam int DONE_LAT = 306;
    localparam int NSTREAM  = 133;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty, rx_done_tick, frame_err, overrun;

    int checks = 0;
    int fails = 0;
    int cyc;
    int done_total = 0;
    int last_done_cyc = 0;
    int last_k0 = 0;
    logic strobe_done;

    uart_rx #(.CLKS_PER_TICK(CPT), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd(rd), .clr_err(clr_err),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_done_tick(rx_done_tick),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #31.25 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        while (cyc % 2 != 0) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        align();
        last_k0 = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    // which: 1 = rd, 2 = clr_err, asserted in the stop-sample cycle
    task automatic send_strobed(input logic [7:0] d, input logic stop, input int which);
        align();
        fork
            send_byte(d, stop);
            begin
                repeat (DONE_LAT - 1) @(negedge clk);
                if (which == 1) rd = 1'b1;
                else            clr_err = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                clr_err = 1'b0;
                strobe_done = rx_done_tick;
            end
        join
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(5);
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h expected 00", rx_data); end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL reset_rx_empty got %b expected 1", rx_empty); end
        checks++; if (rx_done_tick !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", rx_done_tick); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b expected 0", overrun); end
        reset = 1'b1;
        idle(2 * BIT);
    endtask

    task automatic test_single_byte();
        int d0;
        d0 = done_total;
        send_byte(8'h30, 1'b1);
        idle(BIT);
        checks++; if (done_total - d0 !== 1) begin fails++; $display("FAIL single_done_count got %0d expected 1", done_total - d0); end
        checks++; if (last_done_cyc - last_k0 !== DONE_LAT) begin fails++; $display("FAIL single_latency got %0d expected %0d", last_done_cyc - last_k0, DONE_LAT); end
        checks++; if (rx_data !== 8'h30) begin fails++; $display("FAIL single_data got %h expected 30", rx_data); end
        checks++; if (rx_empty !== 1'b0) begin fails++; $display("FAIL single_empty got %b expected 0", rx_empty); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL single_flags got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        pop();
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got %b expected 1", rx_empty); end
        pop();
        idle(1);
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL rd_when_empty got %b expected 1", rx_empty); end
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_total;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * BIT);
        checks++; if (done_total - d0 !== 0) begin fails++; $display("FAIL glitch_done got %0d expected 0", done_total - d0); end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL glitch_empty got %b expected 1", rx_empty); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL glitch_flags got fe=%b ov=%b expected 0 0", frame_err, overrun); end
    endtask

    task automatic test_frame_err();
        int d0;
        d0 = done_total;
        send_byte(8'h55, 1'b0);
        idle(BIT);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set got %b expected 1", frame_err); end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL ferr_empty got %b expected 1", rx_empty); end
        checks++; if (done_total - d0 !== 0) begin fails++; $display("FAIL ferr_done got %0d expected 0", done_total - d0); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear got %b expected 0", frame_err); end
        send_strobed(8'h55, 1'b0, 2);
        idle(BIT);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set_wins got %b expected 1", frame_err); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        d0 = done_total;
        send_byte(8'h41, 1'b1);
        idle(BIT);
        checks++; if (rx_data !== 8'h41 || rx_empty !== 1'b0) begin fails++; $display("FAIL ferr_next_byte got %h empty=%b expected 41 empty=0", rx_data, rx_empty); end
        checks++; if (done_total - d0 !== 1 || frame_err !== 1'b0) begin fails++; $display("FAIL ferr_next_done got %0d fe=%b expected 1 fe=0", done_total - d0, frame_err); end
        pop();
    endtask

    task automatic test_overrun();
        int d0;
        d0 = done_total;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        idle(BIT);
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b expected 1", overrun); end
        checks++; if (done_total - d0 !== DEPTH) begin fails++; $display("FAIL ovr_done got %0d expected %0d", done_total - d0, DEPTH); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ovr_frame_err got %b expected 0", frame_err); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rx_empty !== 1'b0 || rx_data !== 8'(i + 1)) begin fails++; $display("FAIL ovr_read[%0d] got %h empty=%b expected %h empty=0", i, rx_data, rx_empty, 8'(i + 1)); end
            pop();
        end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL ovr_drained got %b expected 1", rx_empty); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b expected 0", overrun); end
    endtask

    task automatic test_push_rd_full();
        logic [7:0] expv;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1);
        idle(BIT);
        send_strobed(8'h99, 1'b1, 1);
        checks++; if (strobe_done !== 1'b1) begin fails++; $display("FAIL pushrd_done got %b expected 1", strobe_done); end
        idle(BIT);
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL pushrd_overrun got %b expected 0", overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            expv = (i == DEPTH - 1) ? 8'h99 : 8'h10 + 8'(i + 1);
            checks++; if (rx_empty !== 1'b0 || rx_data !== expv) begin fails++; $display("FAIL pushrd_read[%0d] got %h empty=%b expected %h empty=0", i, rx_data, rx_empty, expv); end
            pop();
        end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL pushrd_drained got %b expected 1", rx_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [NSTREAM];
        logic [7:0] tail [5];
        int got;
        int guard;
        tail = '{8'h0A, 8'h64, 8'h6F, 8'h6E, 8'h65};
        for (int k = 0; k < NSTREAM; k++) exp_q[k] = (k < 128) ? 8'h30 : tail[k - 128];
        got = 0;
        guard = 0;
        align();
        fork
            begin
                for (int k = 0; k < NSTREAM; k++) send_byte(exp_q[k], 1'b1);
            end
            begin
                while (got < NSTREAM && guard < NSTREAM * BIT * 12) begin
                    @(negedge clk);
                    guard++;
                    if (rx_done_tick) begin
                        checks++;
                        if (rx_data !== exp_q[got]) begin fails++; $display("FAIL stream_byte[%0d] got %h expected %h", got, rx_data, exp_q[got]); end
                        got++;
                        rd = 1'b1;
                    end else begin
                        rd = 1'b0;
                    end
                end
                @(negedge clk);
                rd = 1'b0;
            end
        join
        checks++; if (got !== NSTREAM) begin fails++; $display("FAIL stream_count got %0d expected %0d", got, NSTREAM); end
        idle(BIT);
        checks++; if (rx_empty !== 1'b1 || overrun !== 1'b0) begin fails++; $display("FAIL stream_end got empty=%b ov=%b expected 1 0", rx_empty, overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        send_byte(8'h5A, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(BIT);
        align();
        rx = 1'b0;
        idle(BIT);
        rx = 1'b1;
        idle(BIT);
        rx = 1'b0;
        idle(BIT + BIT / 2);
        reset = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data got %h expected 00", rx_data); end
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got %b expected 1", rx_empty); end
        checks++; if (rx_done_tick !== 1'b0) begin fails++; $display("FAIL midrst_done got %b expected 0", rx_done_tick); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL midrst_flags got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        rx = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(2 * BIT);
        d0 = done_total;
        send_byte(8'hA7, 1'b1);
        idle(BIT);
        checks++; if (rx_data !== 8'hA7 || rx_empty !== 1'b0) begin fails++; $display("FAIL midrst_next got %h empty=%b expected a7 empty=0", rx_data, rx_empty); end
        checks++; if (done_total - d0 !== 1 || frame_err !== 1'b0) begin fails++; $display("FAIL midrst_next_done got %0d fe=%b expected 1 fe=0", done_total - d0, frame_err); end
        pop();
        checks++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL midrst_drained got %b expected 1", rx_empty); end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_rd_full();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
